ftdi_fifo_responder: RTL
========================

Name: ftdi_fifo_responder

Overview:
- Device-side emulation of the FTDI asynchronous 245-FIFO pin interface. It drives rxf_n and txe_n, responds to the rd_n and wr_n strobes, and owns the adbus data path.
- Instantiated in loopback builds and in benches opposite the host-side FTDI interface, so the host logic runs without an FTDI chip present.
- A PC-side valid/ready stream pair stands in for USB traffic: pc_tx feeds bytes toward the host, and pc_rx drains bytes written by the host.

Parameters:
- DEPTH, 16, entries per internal FIFO. Must be a power of 2 and at least 2.
- RXF_GAP, 2, cycles rxf_n is held high after each read strobe ends. Minimum 1.
- TXE_GAP, 2, cycles txe_n is held high after each write strobe ends. Minimum 1.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- rd_n  in  1  host read strobe, active low.
- wr_n  in  1  host write strobe, active low.
- adbus_in  in  8  data driven by the host during writes.
- adbus_out  out  8  data presented to the host during reads.
- adbus_oe  out  1  responder drives adbus.
- rxf_n  out  1  low when a byte is available for the host to read.
- txe_n  out  1  low when the responder can accept a host write.
- pc_tx_data  in  8  PC byte destined for the host.
- pc_tx_valid  in  1  pc_tx_data is valid.
- pc_tx_ready  out  1  = !tofifo_full.
- pc_rx_data  out  8  byte written by the host.
- pc_rx_valid  out  1  = !fromfifo_empty.
- pc_rx_ready  in  1  PC consumes pc_rx_data.
- protocol_err  out  1  sticky strobe-violation flag.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Both FIFOs are emptied.
  - rxf_n=1, txe_n=1, protocol_err=0, adbus_oe=0.
  - Gap counters are cleared, and both FSMs return to IDLE.
  - A reset asserted mid-strobe discards the transfer in progress.
- Edge detection: rd_n and wr_n are registered once (rd_q, wr_q).
  - A falling edge is strobe low with the registered copy high.
  - A rising edge is strobe high with the registered copy low.
  - The registered copies reset to 1.
- Internal FIFOs: both are first-word-fall-through. The head word is visible without a pop.
  - tofifo: PC to host.
  - fromfifo: host to PC.
- Read FSM (R_IDLE, R_ACTIVE, R_GAP):
  - rxf_n is a register. It is 0 only in R_IDLE with tofifo non-empty.
  - adbus_out is always the tofifo head.
  - adbus_oe = !rd_n & reset_n, combinationally, so data is valid in the same cycle rd_n falls.
  - R_IDLE -> R_ACTIVE on a falling rd_n edge while rxf_n=0.
  - R_ACTIVE -> R_GAP on a rising rd_n edge. That edge pops tofifo, and rxf_n=1 from the next cycle.
  - R_GAP counts RXF_GAP cycles, then goes to R_IDLE.
  - Exactly one pop per strobe, regardless of strobe width.
- Write FSM (W_IDLE, W_ACTIVE, W_GAP):
  - txe_n is 0 only in W_IDLE with fromfifo not full.
  - A falling wr_n edge while txe_n=0 pushes adbus_in, as sampled in that first low cycle, and moves to W_ACTIVE. txe_n=1 from the next cycle.
  - W_ACTIVE -> W_GAP on a rising wr_n edge.
  - W_GAP counts TXE_GAP cycles, then goes to W_IDLE.
- PC side:
  - A tofifo push occurs when pc_tx_valid & pc_tx_ready.
  - A fromfifo pop occurs when pc_rx_valid & pc_rx_ready.
  - Push and pop in the same cycle on one FIFO are legal: the count is unchanged, and a push into a FIFO that is full but popping that cycle is refused, since ready is computed from the registered full flag.
- Boundary conditions:
  - tofifo empties → rxf_n stays 1 after the gap until new data arrives.
  - fromfifo full → txe_n stays 1 until the PC pops, then goes low the following cycle (if in W_IDLE).
  - Pointers wrap modulo DEPTH. The count width is log2(DEPTH)+1.
- protocol_err is set sticky on any of:
  - a falling rd_n edge with rxf_n=1; no pop occurs, and oe is still driven.
  - a falling wr_n edge with txe_n=1; the data is dropped.
  - rd_n and wr_n both low in the same cycle; both are still serviced per their FSMs.
- protocol_err is cleared only by reset.

Decomposition:
- ftdi_pkg: read/write FSM state enums, and a BYTE_W=8 constant.
- Sub-module ftdi_resp_fifo: a synchronous FWFT FIFO parameterized by DEPTH, with push/pop/full/empty/count. It is instantiated twice.
- FSMs and edge detection live in the top module.

Test Plan:
- Single read:
  - Stimulus: after reset, push 0xA5 on pc_tx; hold rd_n low for 2 cycles.
  - Response: rxf_n=0 one cycle after the push; adbus_oe=1 and adbus_out=0xA5 in the first rd_n-low cycle.
  - Response: rxf_n=1 from the cycle after the rd_n rising edge, for RXF_GAP cycles; it then stays 1 because tofifo is empty.
- Single write:
  - Stimulus: drive adbus_in=0x3C with wr_n low for 2 cycles.
  - Response: pc_rx_valid=1 and pc_rx_data=0x3C the next cycle; txe_n high for the strobe plus TXE_GAP cycles, then 0.
- Burst and wrap:
  - Stimulus: push 0x00..0x1F on pc_tx with DEPTH=16.
  - Response: pc_tx_ready drops after 16 accepts.
  - Stimulus: perform 32 reads, interleaving the remaining pushes.
  - Response: the host sees 0x00..0x1F in order, and protocol_err=0.
- Write full:
  - Stimulus: perform 16 host writes with pc_rx_ready=0.
  - Response: txe_n stays 1.
  - Stimulus: a 17th wr_n strobe.
  - Response: protocol_err=1, and the data is not stored.
  - Stimulus: a single pc_rx pop.
  - Response: txe_n returns to 0.
- Reset mid-read:
  - Stimulus: deassert reset_n during R_ACTIVE with 3 bytes queued.
  - Response: rxf_n=1, txe_n=1, adbus_oe=0 at the reset edge; both FIFOs empty afterwards; protocol_err=0.
- Simultaneous strobes:
  - Stimulus: rd_n and wr_n fall in the same cycle with both flags low.
  - Response: one pop and one push occur, and protocol_err=1.

Source files
------------

// File: rtl/ftdi_pkg.sv
// Shared types for the FTDI 245-FIFO device-side responder.
package ftdi_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACTIVE = 2'd1,
    R_GAP    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_GAP    = 2'd2
  } wr_state_t;
endpackage

// File: rtl/ftdi_resp_fifo.sv
// Synchronous first-word-fall-through FIFO: head is visible without a pop.
module ftdi_resp_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ftdi_fifo_responder.sv
// Device-side emulation of the FTDI async 245-FIFO pins, bridging to PC-side
// valid/ready streams. Handshakes: a transfer happens on a clock edge where valid & ready.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int RXF_GAP = 2,
  parameter int TXE_GAP = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [BYTE_W-1:0] adbus_in,
  output logic [BYTE_W-1:0] adbus_out,
  output logic              adbus_oe,
  output logic              rxf_n,
  output logic              txe_n,
  input  logic [BYTE_W-1:0] pc_tx_data,
  input  logic              pc_tx_valid,
  output logic              pc_tx_ready,
  output logic [BYTE_W-1:0] pc_rx_data,
  output logic              pc_rx_valid,
  input  logic              pc_rx_ready,
  output logic              protocol_err
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int RGW = $clog2(RXF_GAP + 1);
  localparam int TGW = $clog2(TXE_GAP + 1);

  rd_state_t       rd_state, rd_next;
  wr_state_t       wr_state, wr_next;
  logic [RGW-1:0]  rd_gap;
  logic [TGW-1:0]  wr_gap;
  logic            rd_q, wr_q;
  logic            rd_fall, rd_rise, wr_fall, wr_rise;
  logic            to_push, to_pop, to_full, to_empty;
  logic            from_push, from_pop, from_full, from_empty;
  logic [CW-1:0]   to_count, from_count, to_count_nx, from_count_nx;
  logic            err_set;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_q <= 1'b1;
      wr_q <= 1'b1;
    end else begin
      rd_q <= rd_n;
      wr_q <= wr_n;
    end
  end

  assign rd_fall = !rd_n & rd_q;
  assign rd_rise = rd_n & !rd_q;
  assign wr_fall = !wr_n & wr_q;
  assign wr_rise = wr_n & !wr_q;

  assign pc_tx_ready = !to_full;
  assign pc_rx_valid = !from_empty;
  assign to_push     = pc_tx_valid & pc_tx_ready;
  assign from_pop    = pc_rx_valid & pc_rx_ready;
  assign adbus_oe    = !rd_n & reset_n;

  ftdi_resp_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tofifo (
    .clock(clock), .reset_n(reset_n),
    .push(to_push), .push_data(pc_tx_data), .pop(to_pop),
    .head(adbus_out), .full(to_full), .empty(to_empty), .count(to_count)
  );

  ftdi_resp_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fromfifo (
    .clock(clock), .reset_n(reset_n),
    .push(from_push), .push_data(adbus_in), .pop(from_pop),
    .head(pc_rx_data), .full(from_full), .empty(from_empty), .count(from_count)
  );

  // State registers and gap counters for both FSMs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rd_gap   <= '0;
      wr_gap   <= '0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      rd_gap   <= (rd_state == R_GAP) ? rd_gap + RGW'(1) : '0;
      wr_gap   <= (wr_state == W_GAP) ? wr_gap + TGW'(1) : '0;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:   if (rd_fall && !rxf_n) rd_next = R_ACTIVE;
      R_ACTIVE: if (rd_rise) rd_next = R_GAP;
      R_GAP:    if (rd_gap == RGW'(RXF_GAP - 1)) rd_next = R_IDLE;
      default:  rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:   if (wr_fall && !txe_n) wr_next = W_ACTIVE;
      W_ACTIVE: if (wr_rise) wr_next = W_GAP;
      W_GAP:    if (wr_gap == TGW'(TXE_GAP - 1)) wr_next = W_IDLE;
      default:  wr_next = W_IDLE;
    endcase
  end

  // The pop lands on the rising strobe edge, so a wide strobe still pops once.
  always_comb begin
    to_pop = 1'b0;
    if (rd_state == R_ACTIVE && rd_rise && !to_empty) to_pop = 1'b1;
  end

  always_comb begin
    from_push = 1'b0;
    if (wr_state == W_IDLE && wr_fall && !txe_n && !from_full) from_push = 1'b1;
  end

  assign err_set = (rd_fall & rxf_n) | (wr_fall & txe_n) | (!rd_n & !wr_n);

  // Flags are registered from next-cycle state so they always match FSM + FIFO occupancy.
  assign to_count_nx   = to_count + CW'(to_push) - CW'(to_pop);
  assign from_count_nx = from_count + CW'(from_push) - CW'(from_pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rxf_n        <= 1'b1;
      txe_n        <= 1'b1;
      protocol_err <= 1'b0;
    end else begin
      rxf_n <= !(rd_next == R_IDLE && to_count_nx != '0);
      txe_n <= !(wr_next == W_IDLE && from_count_nx != CW'(DEPTH));
      if (err_set) protocol_err <= 1'b1;
    end
  end
endmodule
